// File: rtl/ps2_ascii_decoder_pkg.sv
// Shared scan-code constants, prefix FSM encoding and helpers for the PS/2 ASCII decoder.
package ps2_ascii_decoder_pkg;

  localparam logic [7:0] SC_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] SC_PREFIX_BRK = 8'hF0;
  localparam logic [7:0] SC_LSHIFT     = 8'h12;
  localparam logic [7:0] SC_RSHIFT     = 8'h59;
  localparam logic [7:0] SC_CAPS       = 8'h58;
  localparam logic [7:0] SC_ENTER      = 8'h5A;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_EXT     = 2'b01,
    ST_BRK     = 2'b10,
    ST_EXT_BRK = 2'b11
  } prefix_state_e;

  // Keyboard housekeeping bytes (BAT result, ACK, resend, errors) that carry no key event.
  function automatic logic is_discard(input logic [7:0] code);
    logic r;
    case (code)
      8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF: r = 1'b1;
      default:                           r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_ascii_lut.sv
// Combinational set-2 make-code to ASCII map with Shift/Caps case selection.
module ps2_ascii_lut
  import ps2_ascii_decoder_pkg::*;
(
  input  logic [7:0] code_i,
  input  logic       ext_i,
  input  logic       shift_i,
  input  logic       caps_i,
  output logic [7:0] ascii_o,
  output logic       hit_o
);

  logic [7:0] letter;
  logic [7:0] digit_ch;
  logic       digit_hit;

  always_comb begin
    letter = 8'h00;
    case (code_i)
      8'h1C: letter = "a";
      8'h32: letter = "b";
      8'h21: letter = "c";
      8'h23: letter = "d";
      8'h24: letter = "e";
      8'h2B: letter = "f";
      8'h34: letter = "g";
      8'h33: letter = "h";
      8'h43: letter = "i";
      8'h3B: letter = "j";
      8'h42: letter = "k";
      8'h4B: letter = "l";
      8'h3A: letter = "m";
      8'h31: letter = "n";
      8'h44: letter = "o";
      8'h4D: letter = "p";
      8'h15: letter = "q";
      8'h2D: letter = "r";
      8'h1B: letter = "s";
      8'h2C: letter = "t";
      8'h3C: letter = "u";
      8'h2A: letter = "v";
      8'h1D: letter = "w";
      8'h22: letter = "x";
      8'h35: letter = "y";
      8'h1A: letter = "z";
      default: letter = 8'h00;
    endcase
  end

  // Caps Lock deliberately does not affect the digit row.
  always_comb begin
    digit_hit = 1'b1;
    digit_ch  = 8'h00;
    case (code_i)
      8'h45: digit_ch = shift_i ? ")" : "0";
      8'h16: digit_ch = shift_i ? "!" : "1";
      8'h1E: digit_ch = shift_i ? "@" : "2";
      8'h26: digit_ch = shift_i ? "#" : "3";
      8'h25: digit_ch = shift_i ? "$" : "4";
      8'h2E: digit_ch = shift_i ? "%" : "5";
      8'h36: digit_ch = shift_i ? "^" : "6";
      8'h3D: digit_ch = shift_i ? "&" : "7";
      8'h3E: digit_ch = shift_i ? "*" : "8";
      8'h46: digit_ch = shift_i ? "(" : "9";
      default: digit_hit = 1'b0;
    endcase
  end

  always_comb begin
    ascii_o = 8'h00;
    hit_o   = 1'b0;
    if (ext_i) begin
      if (code_i == SC_ENTER) begin
        ascii_o = 8'h0D;
        hit_o   = 1'b1;
      end
    end else if (letter != 8'h00) begin
      ascii_o = (shift_i ^ caps_i) ? (letter - 8'h20) : letter;
      hit_o   = 1'b1;
    end else if (digit_hit) begin
      ascii_o = digit_ch;
      hit_o   = 1'b1;
    end else begin
      case (code_i)
        8'h29: begin ascii_o = 8'h20; hit_o = 1'b1; end
        8'h5A: begin ascii_o = 8'h0D; hit_o = 1'b1; end
        8'h66: begin ascii_o = 8'h08; hit_o = 1'b1; end
        default: begin ascii_o = 8'h00; hit_o = 1'b0; end
      endcase
    end
  end

endmodule

// File: rtl/ps2_ascii_decoder.sv
// PS/2 set-2 scan-code decoder: prefix FSM, Shift/Caps tracking, ASCII map and output FIFO.
// state   | meaning
// IDLE    | no prefix pending; next byte is a make or a prefix
// EXT     | E0 seen; next byte is an extended make or F0
// BRK     | F0 seen; next byte is a break
// EXT_BRK | E0 F0 seen; next byte is an extended break
module ps2_ascii_decoder
  import ps2_ascii_decoder_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       code_in,
  input  logic             code_valid,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             shift_o,
  output logic             caps_o,
  output logic             overflow,
  output logic [CNT_W-1:0] fill
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  prefix_state_e state_q, state_d;
  logic lshift_q, lshift_d, rshift_q, rshift_d;
  logic caps_q, caps_d, caps_held_q, caps_held_d;
  logic overflow_q, overflow_d;
  logic make_ev, brk_ev, ext_ev;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] fill_q;
  logic [7:0]       lut_ascii;
  logic             lut_hit;
  logic             full, pop, push_req, push, drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      caps_q      <= 1'b0;
      caps_held_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      caps_q      <= caps_d;
      caps_held_q <= caps_held_d;
      overflow_q  <= overflow_d;
    end
  end

  always_comb begin
    state_d = state_q;
    make_ev = 1'b0;
    brk_ev  = 1'b0;
    ext_ev  = 1'b0;
    if (code_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (code_in == SC_PREFIX_EXT)      state_d = ST_EXT;
          else if (code_in == SC_PREFIX_BRK) state_d = ST_BRK;
          else if (!is_discard(code_in))     make_ev = 1'b1;
        end
        ST_EXT: begin
          if (code_in == SC_PREFIX_BRK) begin
            state_d = ST_EXT_BRK;
          end else begin
            make_ev = 1'b1;
            ext_ev  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_BRK: begin
          brk_ev  = 1'b1;
          state_d = ST_IDLE;
        end
        ST_EXT_BRK: begin
          brk_ev  = 1'b1;
          ext_ev  = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // caps_held stops typematic repeats of Caps Lock from re-toggling.
  always_comb begin
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    caps_d      = caps_q;
    caps_held_d = caps_held_q;
    if (make_ev && !ext_ev) begin
      if (code_in == SC_LSHIFT) lshift_d = 1'b1;
      if (code_in == SC_RSHIFT) rshift_d = 1'b1;
      if (code_in == SC_CAPS) begin
        if (!caps_held_q) caps_d = ~caps_q;
        caps_held_d = 1'b1;
      end
    end
    if (brk_ev && !ext_ev) begin
      if (code_in == SC_LSHIFT) lshift_d = 1'b0;
      if (code_in == SC_RSHIFT) rshift_d = 1'b0;
      if (code_in == SC_CAPS)   caps_held_d = 1'b0;
    end
  end

  assign shift_o = lshift_q | rshift_q;
  assign caps_o  = caps_q;

  ps2_ascii_lut u_lut (
    .code_i  (code_in),
    .ext_i   (ext_ev),
    .shift_i (shift_o),
    .caps_i  (caps_q),
    .ascii_o (lut_ascii),
    .hit_o   (lut_hit)
  );

  // When full, a same-cycle pop frees the slot the write lands in, so order is preserved.
  assign full       = (fill_q == CNT_W'(FIFO_DEPTH));
  assign pop        = out_valid & out_ready;
  assign push_req   = make_ev & lut_hit;
  assign push       = push_req & (~full | pop);
  assign drop       = push_req & full & ~pop;
  assign overflow_d = overflow_q | drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= lut_ascii;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   fill_q <= fill_q + 1'b1;
        2'b01:   fill_q <= fill_q - 1'b1;
        default: fill_q <= fill_q;
      endcase
    end
  end

  assign out_valid = (fill_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign overflow  = overflow_q;
  assign fill      = fill_q;

endmodule
